// File: rtl/commit_halt_monitor_if.sv
// Commit-side bus between the core's writeback stage and the halt monitor.
// The master drives the raw commits; the slave returns them tagged with retirement order.
interface commit_halt_monitor_if #(
    parameter int NUM_LANES = 2,
    parameter int PC_W      = 32,
    parameter int ORDER_W   = 64
);
    logic [NUM_LANES-1:0]         in_valid;
    logic [NUM_LANES*PC_W-1:0]    in_pc;
    logic [NUM_LANES*PC_W-1:0]    in_next_pc;
    logic [NUM_LANES-1:0]         out_valid;
    logic [NUM_LANES*ORDER_W-1:0] out_order;

    modport master (
        output in_valid, in_pc, in_next_pc,
        input  out_valid, out_order
    );

    modport slave (
        input  in_valid, in_pc, in_next_pc,
        output out_valid, out_order
    );
endinterface

// File: rtl/commit_halt_monitor.sv
// Orders up to NUM_LANES commits per cycle, detects program end as a repeated
// self-loop commit followed by a drain period, and flags idle timeouts and lane gaps.
module commit_halt_monitor #(
    parameter int NUM_LANES      = 2,
    parameter int PC_W           = 32,
    parameter int ORDER_W        = 64,
    parameter int HALT_REPEAT    = 1,
    parameter int DRAIN_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    commit_halt_monitor_if.slave  bus,
    output logic                  halt,
    output logic                  timeout,
    output logic                  lane_error,
    output logic [ORDER_W-1:0]    commit_count
);

    localparam int LOOP_W  = $clog2(HALT_REPEAT + 1);
    localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int IDLE_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [LOOP_W-1:0]  LOOP_MAX  = LOOP_W'(HALT_REPEAT);
    localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                       state, state_next;
    logic [LOOP_W-1:0]            loop_cnt, loop_cnt_next;
    logic [PC_W-1:0]              loop_pc, loop_pc_next;
    logic [DRAIN_W-1:0]           drain_cnt, drain_cnt_next;
    logic [IDLE_W-1:0]            idle_cnt, idle_cnt_next;
    logic [ORDER_W-1:0]           base, base_next;
    logic [NUM_LANES-1:0]         out_valid_q, out_valid_next;
    logic [NUM_LANES*ORDER_W-1:0] out_order_q, out_order_next;
    logic                         timeout_next;
    logic                         lane_error_next;

    logic [ORDER_W-1:0]           running;
    logic [NUM_LANES*ORDER_W-1:0] order_cand;
    logic [PC_W-1:0]              y_pc, y_next_pc;
    logic                         any_valid;
    logic                         gap;

    assign bus.out_valid = out_valid_q;
    assign bus.out_order = out_order_q;
    assign halt          = (state == HALTED);
    assign commit_count  = base;

    // State register for the FSM and every piece of monitor state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            loop_cnt    <= '0;
            loop_pc     <= '0;
            drain_cnt   <= '0;
            idle_cnt    <= '0;
            base        <= '0;
            out_valid_q <= '0;
            out_order_q <= '0;
            timeout     <= 1'b0;
            lane_error  <= 1'b0;
        end else begin
            state       <= state_next;
            loop_cnt    <= loop_cnt_next;
            loop_pc     <= loop_pc_next;
            drain_cnt   <= drain_cnt_next;
            idle_cnt    <= idle_cnt_next;
            base        <= base_next;
            out_valid_q <= out_valid_next;
            out_order_q <= out_order_next;
            timeout     <= timeout_next;
            lane_error  <= lane_error_next;
        end
    end

    // Next-state logic: prefix ordering, youngest-lane loop tracking, drain and watchdog.
    always_comb begin
        state_next      = state;
        loop_cnt_next   = loop_cnt;
        loop_pc_next    = loop_pc;
        drain_cnt_next  = drain_cnt;
        idle_cnt_next   = idle_cnt;
        base_next       = base;
        out_valid_next  = '0;
        out_order_next  = out_order_q;
        timeout_next    = timeout;
        lane_error_next = lane_error;
        running         = '0;
        order_cand      = '0;
        y_pc            = '0;
        y_next_pc       = '0;
        gap             = 1'b0;
        any_valid       = |bus.in_valid;

        for (int i = 0; i < NUM_LANES; i++) begin
            order_cand[i*ORDER_W +: ORDER_W] = base + running;
            if (bus.in_valid[i]) begin
                running   = running + ORDER_W'(1);
                y_pc      = bus.in_pc[i*PC_W +: PC_W];
                y_next_pc = bus.in_next_pc[i*PC_W +: PC_W];
            end
        end
        for (int i = 1; i < NUM_LANES; i++) begin
            if (bus.in_valid[i] && !bus.in_valid[i-1]) begin
                gap = 1'b1;
            end
        end

        // The edge that enters HALTED still reports its commits; HALTED itself ignores inputs.
        if (state != HALTED) begin
            out_valid_next  = bus.in_valid;
            out_order_next  = order_cand;
            base_next       = base + running;
            lane_error_next = lane_error | gap;
            if (TIMEOUT_CYCLES != 0) begin
                if (any_valid) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt != IDLE_MAX) begin
                    idle_cnt_next = idle_cnt + IDLE_W'(1);
                end
                if (idle_cnt_next == IDLE_MAX) begin
                    timeout_next = 1'b1;
                end
            end
        end

        case (state)
            RUN: begin
                if (any_valid) begin
                    if (y_next_pc == y_pc) begin
                        if (y_pc == loop_pc && loop_cnt != '0) begin
                            if (loop_cnt != LOOP_MAX) begin
                                loop_cnt_next = loop_cnt + LOOP_W'(1);
                            end
                        end else begin
                            loop_cnt_next = LOOP_W'(1);
                            loop_pc_next  = y_pc;
                        end
                    end else begin
                        loop_cnt_next = '0;
                    end
                    if (loop_cnt_next == LOOP_MAX) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_next = HALTED;
                        end else begin
                            state_next     = DRAIN;
                            drain_cnt_next = DRAIN_MAX;
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt <= DRAIN_W'(1)) begin
                    state_next = HALTED;
                end else begin
                    drain_cnt_next = drain_cnt - DRAIN_W'(1);
                end
            end
            default: begin
                state_next = HALTED;
            end
        endcase
    end

endmodule
